// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between I-fetch and D load/store with D priority and a starvation limiter
module mem_port_arbiter #(
   parameter int MAX_D_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_read,
   input  logic [31:0] i_address,
   output logic [31:0] i_rdata,
   output logic        i_resp,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_address,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wmask,
   output logic [31:0] d_rdata,
   output logic        d_resp,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic [31:0] mem_rdata,
   input  logic        mem_resp,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
   localparam logic [3:0] MAX = 4'(MAX_D_STREAK);
   state_t state;
   logic [3:0] streak;
   logic d_pend, i_turn, in_i, in_d;
   assign d_pend = d_read | d_write;
   assign i_turn = i_read & (streak == MAX);
   assign in_i = state == SERVE_I;
   assign in_d = state == SERVE_D;
   // grant decision in IDLE, completion on mem_resp, streak of D grants taken while I waits
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         streak <= '0;
      end else if (state == IDLE) begin
         if (d_pend && !i_turn) begin
            state <= SERVE_D;
            streak <= i_read ? streak + 4'(streak != MAX) : '0;
         end else if (i_read) begin
            state <= SERVE_I;
            streak <= '0;
         end else
            streak <= '0;
      end else if (mem_resp)
         state <= IDLE;
   // port steering follows the granted side; data and resp pass straight through
   always_comb begin
      busy = in_i | in_d;
      mem_read = in_i | (in_d & d_read & ~d_write);
      mem_write = in_d & d_write;
      mem_address = in_i ? i_address : in_d ? d_address : '0;
      mem_wdata = in_d ? d_wdata : '0;
      mem_wmask = (in_d & d_write) ? d_wmask : '0;
      i_rdata = in_i ? mem_rdata : '0;
      i_resp = in_i & mem_resp;
      d_rdata = in_d ? mem_rdata : '0;
      d_resp = in_d & mem_resp;
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scenario tasks plus a randomized run against a transaction-level model
module tb_mem_port_arbiter;
   localparam int MAXS = 4;
   logic clk = 0;
   logic rst;
   logic i_read, i_resp, d_read, d_write, d_resp, mem_read, mem_write, mem_resp, busy;
   logic [31:0] i_address, i_rdata, d_address, d_wdata, d_rdata, mem_address, mem_wdata, mem_rdata;
   logic [3:0] d_wmask, mem_wmask;
   int checks = 0, errors = 0;
   int lat = 0, kick_req = 0;
   logic [31:0] mem [logic [31:0]];

   mem_port_arbiter #(.MAX_D_STREAK(MAXS)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata), .d_wmask(d_wmask),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_resp(mem_resp), .busy(busy)
   );

   always #5 clk = ~clk;

   assert property (@(posedge clk) disable iff (rst) $fell(i_read) |-> $past(i_resp));
   assert property (@(posedge clk) disable iff (rst) $fell(d_read | d_write) |-> $past(d_resp));

   function automatic logic [31:0] rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
      logic [31:0] r = o;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   // memory model: answers a strobe after lat+1 cycles, applies writes with byte enables
   initial begin : responder
      logic act, wr;
      logic [31:0] a, wd;
      logic [3:0] wm;
      int cnt, kick_done;
      mem[32'h60] = 32'h13;
      mem_resp = 0; mem_rdata = 0; cnt = 0; kick_done = 0;
      forever begin
         @(negedge clk);
         act = mem_read | mem_write; wr = mem_write; a = mem_address; wd = mem_wdata; wm = mem_wmask;
         @(posedge clk); #1;
         if (rst || mem_resp) begin
            mem_resp = 0; cnt = 0;
         end else if (kick_req != kick_done) begin
            mem_resp = 1; mem_rdata = 32'hBAD0_0000; kick_done = kick_req;
         end else if (act) begin
            if (cnt >= lat) begin
               mem_resp = 1; cnt = 0;
               if (wr) mem[a] = merge(rd(a), wd, wm); else mem_rdata = rd(a);
            end else cnt++;
         end else cnt = 0;
      end
   end

   task automatic test_reset();
      rst = 1; i_read = 1; i_address = 32'h44; d_read = 1; d_write = 1;
      d_address = 32'h88; d_wdata = '1; d_wmask = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if ({mem_read, mem_write, i_resp, d_resp, busy} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b want 00000", {mem_read, mem_write, i_resp, d_resp, busy}); end
      checks++; if ({mem_address, mem_wdata, mem_wmask} !== 68'h0) begin errors++; $display("FAIL reset_bus: got %h want 0", {mem_address, mem_wdata, mem_wmask}); end
      checks++; if ({i_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", {i_rdata, d_rdata}); end
      i_read = 0; d_read = 0; d_write = 0;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_i_read();
      bit seen = 0;
      lat = 1; i_address = 32'h60; i_read = 1;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (c == 0) begin
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL iread_c0_busy: got %b want 0", busy); end
         end
         if (c == 1) begin
            checks++; if ({mem_read, mem_write} !== 2'b10) begin errors++; $display("FAIL iread_strobe: got %b want 10", {mem_read, mem_write}); end
            checks++; if (mem_address !== 32'h60) begin errors++; $display("FAIL iread_addr: got %h want 60", mem_address); end
         end
         if (i_resp) begin
            seen = 1;
            checks++; if (i_rdata !== 32'h13) begin errors++; $display("FAIL iread_data: got %h want 13", i_rdata); end
            checks++; if (c != 3 || mem_resp !== 1'b1) begin errors++; $display("FAIL iread_resp_cycle: got cycle %0d mem_resp %b want 3 1", c, mem_resp); end
         end
      end
      checks++; if (!seen) begin errors++; $display("FAIL iread_timeout: got no i_resp want one"); end
      @(posedge clk); #1 i_read = 0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL iread_after_busy: got %b want 0", busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_d_write();
      bit seen = 0;
      logic [31:0] exp_word = merge(rd(32'h100), 32'hDEADBEEF, 4'b0011);
      lat = $urandom_range(0, 3);
      d_address = 32'h100; d_wdata = 32'hDEADBEEF; d_wmask = 4'b0011; d_write = 1;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (busy) begin
            checks++; if ({mem_write, mem_read, mem_wmask} !== 6'b10_0011) begin errors++; $display("FAIL dwrite_strobe: got %b want 100011", {mem_write, mem_read, mem_wmask}); end
            checks++; if (mem_wdata !== 32'hDEADBEEF || mem_address !== 32'h100) begin errors++; $display("FAIL dwrite_bus: got %h/%h want deadbeef/100", mem_wdata, mem_address); end
            checks++; if (i_resp !== 1'b0) begin errors++; $display("FAIL dwrite_iresp: got %b want 0", i_resp); end
         end
         if (d_resp) seen = 1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL dwrite_timeout: got no d_resp want one"); end
      @(posedge clk); #1 d_write = 0;
      @(negedge clk);
      checks++; if ({d_resp, busy} !== 2'b00) begin errors++; $display("FAIL dwrite_single_pulse: got %b want 00", {d_resp, busy}); end
      checks++; if (rd(32'h100) !== exp_word) begin errors++; $display("FAIL dwrite_memory: got %h want %h", rd(32'h100), exp_word); end
      @(posedge clk); #1;
   endtask

   task automatic test_both();
      int ti = -1, td = -1;
      bit gap = 0, ir, dr;
      lat = 0; i_address = 32'h200; d_address = 32'h300; i_read = 1; d_read = 1;
      for (int c = 0; c < 30 && ti < 0; c++) begin
         @(negedge clk);
         ir = i_resp; dr = d_resp;
         if (dr) begin
            td = c;
            checks++; if (d_rdata !== rd(32'h300)) begin errors++; $display("FAIL both_ddata: got %h want %h", d_rdata, rd(32'h300)); end
         end
         if (ir) begin
            ti = c;
            checks++; if (i_rdata !== rd(32'h200)) begin errors++; $display("FAIL both_idata: got %h want %h", i_rdata, rd(32'h200)); end
         end
         if (td >= 0 && ti < 0 && !busy) gap = 1;
         @(posedge clk); #1;
         if (ir) i_read = 0;
         if (dr) d_read = 0;
      end
      checks++; if (td < 0 || ti <= td || !gap) begin errors++; $display("FAIL both_order: got d@%0d i@%0d gap %0b want d first, idle, then i", td, ti, gap); end
      i_read = 0; d_read = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_streak();
      int n = 0, c = 0;
      bit ir, dr, exp_i;
      lat = 0; i_address = 32'h1000; d_address = 32'h2000; i_read = 1; d_read = 1;
      while ((i_read || d_read) && c < 300) begin
         @(negedge clk);
         ir = i_resp; dr = d_resp;
         if (ir || dr) begin
            exp_i = (n % (MAXS + 1)) == MAXS;
            checks++; if (ir !== exp_i) begin errors++; $display("FAIL streak_order_%0d: got i_resp %b want %b", n, ir, exp_i); end
            n++;
         end
         @(posedge clk); #1;
         if (n >= 10 && ir) i_read = 0;
         if (n >= 10 && dr) d_read = 0;
         c++;
      end
      checks++; if (c >= 300) begin errors++; $display("FAIL streak_timeout: got %0d completions want >= 10", n); end
      i_read = 0; d_read = 0;
   endtask

   task automatic test_reset_mid();
      int n = 0, nd = 0;
      bit seen_i = 0, got_i = 0, hit = 0, ir, dr;
      lat = 3; i_address = 32'h400; i_read = 1;
      d_address = 32'h500; d_wdata = $urandom; d_wmask = 4'hF; d_write = 1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (d_resp) n++;
         if (i_resp) seen_i = 1;
         if (n == 3 && mem_write && !d_resp) begin hit = 1; break; end
         @(posedge clk); #1;
      end
      checks++; if (!hit || seen_i) begin errors++; $display("FAIL rstmid_setup: got 4th D grant %0b, i_resp seen %0b want 1 0", hit, seen_i); end
      #1 rst = 1;
      #1;
      checks++; if ({mem_write, busy, d_resp, mem_wmask} !== 7'b0) begin errors++; $display("FAIL rstmid_immediate: got %b want 0000000", {mem_write, busy, d_resp, mem_wmask}); end
      @(posedge clk); #2 rst = 0;
      for (int c = 0; c < 300 && (i_read || d_write); c++) begin
         @(negedge clk);
         ir = i_resp; dr = d_resp;
         if (dr && !got_i) nd++;
         if (ir) begin
            got_i = 1;
            checks++; if (nd != MAXS) begin errors++; $display("FAIL rstmid_streak: got %0d D before I want %0d", nd, MAXS); end
         end
         @(posedge clk); #1;
         if (ir) i_read = 0;
         if (dr && got_i) d_write = 0;
      end
      checks++; if (!got_i || d_write) begin errors++; $display("FAIL rstmid_timeout: got i done %0b d pending %0b want 1 0", got_i, d_write); end
      i_read = 0; d_write = 0;
   endtask

   task automatic test_misc();
      bit seen = 0, kicked = 0;
      lat = 1; d_address = 32'h600; d_wdata = $urandom; d_wmask = 4'b1010; d_read = 1; d_write = 1;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (busy) begin
            checks++; if ({mem_write, mem_read} !== 2'b10) begin errors++; $display("FAIL misc_write_wins: got %b want 10", {mem_write, mem_read}); end
         end
         seen = d_resp;
         @(posedge clk); #1;
         if (seen) begin d_read = 0; d_write = 0; end
      end
      checks++; if (!seen) begin errors++; $display("FAIL misc_timeout: got no d_resp want one"); end
      repeat (2) @(posedge clk);
      #1 kick_req++;
      for (int c = 0; c < 5 && !kicked; c++) begin
         @(negedge clk);
         if (mem_resp) begin
            kicked = 1;
            checks++; if ({i_resp, d_resp, busy, mem_read, mem_write} !== 5'b0) begin errors++; $display("FAIL misc_idle_resp: got %b want 00000", {i_resp, d_resp, busy, mem_read, mem_write}); end
         end
      end
      @(negedge clk);
      checks++; if (!kicked || busy !== 1'b0) begin errors++; $display("FAIL misc_idle_stay: got kicked %0b busy %b want 1 0", kicked, busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int own = 0, run = 0, op;
      bit ir, dr, e_rd, e_wr;
      logic [31:0] e_addr, e_wd, e_ir, e_dr;
      logic [3:0] e_wm;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         e_rd = own == 1 || (own == 2 && d_read && !d_write);
         e_wr = own == 2 && d_write;
         e_addr = own == 1 ? i_address : own == 2 ? d_address : 32'h0;
         e_wd = own == 2 ? d_wdata : 32'h0;
         e_wm = e_wr ? d_wmask : 4'h0;
         e_ir = own == 1 ? mem_rdata : 32'h0;
         e_dr = own == 2 ? mem_rdata : 32'h0;
         checks++;
         if ({busy, mem_read, mem_write, mem_address, mem_wdata, mem_wmask, i_resp, d_resp, i_rdata, d_rdata} !==
             {own != 0, e_rd, e_wr, e_addr, e_wd, e_wm, own == 1 && mem_resp, own == 2 && mem_resp, e_ir, e_dr}) begin
            errors++;
            $display("FAIL random_cycle_%0d: got %h want %h", c,
               {busy, mem_read, mem_write, mem_address, mem_wdata, mem_wmask, i_resp, d_resp, i_rdata, d_rdata},
               {own != 0, e_rd, e_wr, e_addr, e_wd, e_wm, own == 1 && mem_resp, own == 2 && mem_resp, e_ir, e_dr});
         end
         ir = i_resp; dr = d_resp;
         if (ir) begin
            checks++; if (i_rdata !== rd(i_address)) begin errors++; $display("FAIL random_idata_%0d: got %h want %h", c, i_rdata, rd(i_address)); end
         end
         if (dr && !d_write) begin
            checks++; if (d_rdata !== rd(d_address)) begin errors++; $display("FAIL random_ddata_%0d: got %h want %h", c, d_rdata, rd(d_address)); end
         end
         if (own == 0) begin
            if ((d_read || d_write) && !(i_read && run == MAXS)) begin own = 2; run = i_read ? run + 1 : 0; end
            else if (i_read) begin own = 1; run = 0; end
            else run = 0;
         end else if (mem_resp) own = 0;
         @(posedge clk); #1;
         if (ir) i_read = 0;
         if (dr) begin d_read = 0; d_write = 0; end
         lat = $urandom_range(0, 3);
         if (!i_read && c < 2900 && $urandom_range(0, 2) == 0) begin
            i_read = 1; i_address = $urandom;
         end
         if (!d_read && !d_write && c < 2900 && $urandom_range(0, 1) == 0) begin
            op = $urandom_range(0, 2);
            d_read = op != 1; d_write = op != 0;
            d_address = $urandom & 32'hFF; d_wdata = $urandom; d_wmask = 4'($urandom);
         end
      end
      checks++; if ({i_read, d_read, d_write, busy} !== 4'b0) begin errors++; $display("FAIL random_drain: got %b want 0000", {i_read, d_read, d_write, busy}); end
   endtask

   initial begin
      rst = 1; i_read = 0; d_read = 0; d_write = 0;
      i_address = 0; d_address = 0; d_wdata = 0; d_wmask = 0;
      test_reset();
      test_i_read();
      test_d_write();
      test_both();
      test_streak();
      test_reset_mid();
      test_misc();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule
